// File: rtl/mult_div_unit.sv
// Iterative signed 32-bit multiply (shift-add) / divide (restoring), one bit per cycle on magnitudes.
// Results land 33 cycles after start (1 cycle on divide by zero); start is ignored while busy.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH:0]     ONE_MAG = 1;
    localparam logic [WIDTH-1:0]   ONE_W   = 1;
    localparam logic [2*WIDTH-1:0] ONE_2W  = 1;
    localparam logic [CW-1:0]      ONE_CNT = 1;
    localparam logic [CW-1:0]      LAST    = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [WIDTH:0]     a_mag;
    logic [WIDTH:0]     b_mag;
    logic [WIDTH-1:0]   opr;
    logic [2*WIDTH-1:0] acc;
    logic               sign_a;
    logic               neg_res;
    logic               is_div;
    logic               dz;

    logic [WIDTH:0]     a_abs;
    logic [WIDTH:0]     b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               unused_bits;

    // Magnitudes are WIDTH+1 bits so that |-2^(WIDTH-1)| is representable.
    always_comb begin
        a_abs = A[WIDTH-1] ? ({1'b0, ~A} + ONE_MAG) : {1'b0, A};
        b_abs = B[WIDTH-1] ? ({1'b0, ~B} + ONE_MAG) : {1'b0, B};

        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + a_mag;

        div_shift = {acc[2*WIDTH-1:WIDTH], opr[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {1'b0, b_mag};
        rem_next  = div_diff[WIDTH+1] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];

        prod_fix = neg_res ? (~acc + ONE_2W) : acc;
        quo_fix  = neg_res ? (~acc[WIDTH-1:0] + ONE_W) : acc[WIDTH-1:0];
        rem_fix  = sign_a ? (~acc[2*WIDTH-1:WIDTH] + ONE_W) : acc[2*WIDTH-1:WIDTH];

        // Remainder is always below the divisor, so these bits are zero when used.
        unused_bits = div_diff[WIDTH] ^ div_shift[WIDTH];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            a_mag       <= '0;
            b_mag       <= '0;
            opr         <= '0;
            acc         <= '0;
            sign_a      <= 1'b0;
            neg_res     <= 1'b0;
            is_div      <= 1'b0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            HI          <= '0;
            LO          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= start;
                    if (start) begin
                        a_mag   <= a_abs;
                        b_mag   <= b_abs;
                        sign_a  <= A[WIDTH-1];
                        neg_res <= A[WIDTH-1] ^ B[WIDTH-1];
                        acc     <= '0;
                        count   <= '0;
                        is_div  <= op;
                        opr     <= op ? a_abs[WIDTH-1:0] : b_abs[WIDTH-1:0];
                        dz      <= op && (B == '0);
                        if (!op)
                            state <= MULT;
                        else if (B == '0)
                            state <= FINISH;
                        else
                            state <= DIV;
                    end
                end
                MULT: begin
                    if (opr[0])
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    else
                        acc <= {1'b0, acc[2*WIDTH-1:1]};
                    opr   <= {1'b0, opr[WIDTH-1:1]};
                    count <= count + ONE_CNT;
                    if (count == LAST)
                        state <= FINISH;
                end
                DIV: begin
                    // Quotient bits shift into the low half, partial remainder lives in the high half.
                    acc   <= {rem_next, acc[WIDTH-2:0], ~div_diff[WIDTH+1]};
                    opr   <= {opr[WIDTH-2:0], 1'b0};
                    count <= count + ONE_CNT;
                    if (count == LAST)
                        state <= FINISH;
                end
                FINISH: begin
                    done        <= 1'b1;
                    div_by_zero <= dz;
                    if (!dz) begin
                        if (is_div) begin
                            HI <= rem_fix;
                            LO <= quo_fix;
                        end else begin
                            HI <= prod_fix[2*WIDTH-1:WIDTH];
                            LO <= prod_fix[WIDTH-1:0];
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and back-to-back random checks of mult_div_unit against hand values and a 64-bit model.
module tb_mult_div_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    int   lat;
    logic busy_ok, dz_at_done, done_after, busy_after, dz_after, saw_done;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Operands are scrambled after acceptance; optional poke issues a stray start mid-operation.
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b, input int poke);
        op = o; A = a; B = b; start = 1'b1;
        step();
        start = 1'b0; A = $urandom; B = $urandom; op = ~o;
        lat = 0;
        busy_ok = 1'b1;
        do begin
            step();
            lat++;
            if (!busy) busy_ok = 1'b0;
            if (start) start = 1'b0;
            if (lat == poke) begin
                start = 1'b1; op = 1'b1; A = 32'd100; B = 32'd3;
            end
        end while (!done && lat < 100);
        start = 1'b0;
        dz_at_done = div_by_zero;
        step();
        done_after = done;
        busy_after = busy;
        dz_after   = div_by_zero;
    endtask

    logic [31:0] ca, cb;
    logic        co;
    longint      prod, q, r;
    logic [63:0] pv, qv, rv;

    initial begin
        reset = 1'b0; start = 1'b0; op = 1'b0; A = '0; B = '0;
        step();
        step();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dz", div_by_zero, 1'b0);
        check("rst_hi", HI, 32'h0);
        check("rst_lo", LO, 32'h0);
        reset = 1'b1;
        step();

        run_op(1'b0, 32'd7, 32'hFFFFFFFD, 0);
        check("mul7x-3_lat", lat, 33);
        check("mul7x-3_busy", busy_ok, 1'b1);
        check("mul7x-3_dz", dz_at_done, 1'b0);
        check("mul7x-3_hi", HI, 32'hFFFFFFFF);
        check("mul7x-3_lo", LO, 32'hFFFFFFEB);
        check("mul7x-3_pulse", done_after, 1'b0);
        check("mul7x-3_busy_fall", busy_after, 1'b0);

        run_op(1'b1, 32'hFFFFFFF9, 32'd2, 0);
        check("div-7/2_lat", lat, 33);
        check("div-7/2_lo", LO, 32'hFFFFFFFD);
        check("div-7/2_hi", HI, 32'hFFFFFFFF);

        run_op(1'b1, 32'd7, 32'hFFFFFFFE, 0);
        check("div7/-2_lat", lat, 33);
        check("div7/-2_lo", LO, 32'hFFFFFFFD);
        check("div7/-2_hi", HI, 32'h1);

        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
        check("divmin_lo", LO, 32'h80000000);
        check("divmin_hi", HI, 32'h0);
        check("divmin_dz", dz_at_done, 1'b0);

        run_op(1'b0, 32'h80000000, 32'h80000000, 0);
        check("mulmin_hi", HI, 32'h40000000);
        check("mulmin_lo", LO, 32'h0);

        run_op(1'b0, 32'd5, 32'd6, 0);
        check("mul5x6_hi", HI, 32'h0);
        check("mul5x6_lo", LO, 32'd30);

        run_op(1'b1, 32'd9, 32'd0, 0);
        check("dz_lat", lat, 1);
        check("dz_flag", dz_at_done, 1'b1);
        check("dz_pulse_done", done_after, 1'b0);
        check("dz_pulse_flag", dz_after, 1'b0);
        check("dz_hi_kept", HI, 32'h0);
        check("dz_lo_kept", LO, 32'd30);

        run_op(1'b0, 32'd1234, 32'hFFFFE9D2, 10);
        check("poke_lat", lat, 33);
        check("poke_busy", busy_ok, 1'b1);
        check("poke_hi", HI, 32'hFFFFFFFF);
        check("poke_lo", LO, 32'hFF951644);
        check("poke_no_restart", busy_after, 1'b0);

        op = 1'b1; A = 32'd1000; B = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        repeat (15) step();
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_hi", HI, 32'h0);
        check("abort_lo", LO, 32'h0);
        step();
        step();
        reset = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            step();
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 1'b0);

        run_op(1'b1, 32'd100, 32'd7, 0);
        check("after_abort_lat", lat, 33);
        check("after_abort_lo", LO, 32'd14);
        check("after_abort_hi", HI, 32'd2);

        co = 1'b0; ca = $urandom; cb = $urandom;
        op = co; A = ca; B = cb; start = 1'b1;
        step();
        for (int i = 0; i < 1000; i++) begin
            int n;
            n = 0;
            do begin
                step();
                n++;
            end while (!done && n < 40);
            check("b2b_gap", n, (i == 0) ? 33 : 34);
            if (!co) begin
                prod = longint'($signed(ca)) * longint'($signed(cb));
                pv = prod;
                check("b2b_mul_hi", HI, pv[63:32]);
                check("b2b_mul_lo", LO, pv[31:0]);
            end else begin
                q = longint'($signed(ca)) / longint'($signed(cb));
                r = longint'($signed(ca)) % longint'($signed(cb));
                qv = q;
                rv = r;
                check("b2b_div_hi", HI, rv[31:0]);
                check("b2b_div_lo", LO, qv[31:0]);
            end
            co = ~co;
            ca = $urandom;
            cb = $urandom;
            if (co && cb == 32'h0) cb = 32'd1;
            op = co; A = ca; B = cb;
        end
        start = 1'b0;
        repeat (40) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
